// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file held in flip-flops, with write-first read ports,
// synchronous clear and range-checked addresses. All outputs are registered.
module reg_file_2r1w #(
  parameter int                WIDTH     = 4,
  parameter int                DEPTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
  localparam int               ADDR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_err,
  input  logic              rd_en0,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [WIDTH-1:0]  rd_data0,
  output logic              rd_valid0,
  output logic              rd_err0,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_data1,
  output logic              rd_valid1,
  output logic              rd_err1
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic             wr_ok_s;
  logic             wr_oor_s;
  logic             rd_ok0_s;
  logic             rd_ok1_s;
  logic [WIDTH-1:0] rd_mem0_s;
  logic [WIDTH-1:0] rd_mem1_s;
  logic [WIDTH-1:0] rd_next0_s;
  logic [WIDTH-1:0] rd_next1_s;

  logic             wr_err_r;
  logic [WIDTH-1:0] rd_data0_r;
  logic [WIDTH-1:0] rd_data1_r;
  logic             rd_valid0_r;
  logic             rd_valid1_r;
  logic             rd_err0_r;
  logic             rd_err1_r;

  // clr outranks a write, so a write colliding with clr is neither stored nor flagged.
  assign wr_ok_s  = wr_en & ~clr & ({1'b0, wr_addr} < DEPTH_C);
  assign wr_oor_s = wr_en & ~clr & ~({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok0_s = ({1'b0, rd_addr0} < DEPTH_C);
  assign rd_ok1_s = ({1'b0, rd_addr1} < DEPTH_C);

  // Storage lookup for both read ports; the compare loop never indexes past DEPTH.
  always_comb begin
    rd_mem0_s = {WIDTH{1'b0}};
    rd_mem1_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rd_mem0_s = (rd_addr0 == ADDR_W'(i)) ? mem_r[i] : rd_mem0_s;
      rd_mem1_s = (rd_addr1 == ADDR_W'(i)) ? mem_r[i] : rd_mem1_s;
    end
  end

  // Read data as it will look after this edge: clear first, then write-first bypass.
  assign rd_next0_s = !rd_ok0_s                         ? {WIDTH{1'b0}} :
                      clr                               ? RESET_VAL     :
                      (wr_ok_s && wr_addr == rd_addr0)  ? wr_data       : rd_mem0_s;
  assign rd_next1_s = !rd_ok1_s                         ? {WIDTH{1'b0}} :
                      clr                               ? RESET_VAL     :
                      (wr_ok_s && wr_addr == rd_addr1)  ? wr_data       : rd_mem1_s;

  // Entry storage: reset and clear load RESET_VAL, otherwise the addressed entry takes the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_VAL;
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_VAL;
      end
    end else if (wr_ok_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          mem_r[i] <= wr_data;
        end
      end
    end
  end

  // Output registers: status pulses last one cycle, read data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_r    <= 1'b0;
      rd_data0_r  <= {WIDTH{1'b0}};
      rd_data1_r  <= {WIDTH{1'b0}};
      rd_valid0_r <= 1'b0;
      rd_valid1_r <= 1'b0;
      rd_err0_r   <= 1'b0;
      rd_err1_r   <= 1'b0;
    end else begin
      wr_err_r    <= wr_oor_s;
      rd_valid0_r <= rd_en0;
      rd_valid1_r <= rd_en1;
      rd_err0_r   <= rd_en0 & ~rd_ok0_s;
      rd_err1_r   <= rd_en1 & ~rd_ok1_s;
      if (rd_en0) begin
        rd_data0_r <= rd_next0_s;
      end
      if (rd_en1) begin
        rd_data1_r <= rd_next1_s;
      end
    end
  end

  assign wr_err    = wr_err_r;
  assign rd_data0  = rd_data0_r;
  assign rd_data1  = rd_data1_r;
  assign rd_valid0 = rd_valid0_r;
  assign rd_valid1 = rd_valid1_r;
  assign rd_err0   = rd_err0_r;
  assign rd_err1   = rd_err1_r;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w (WIDTH=4, DEPTH=6, RESET_VAL=3): directed cases followed by
// a randomized run, all outputs compared every cycle against an array-based reference.
module tb_reg_file_2r1w;

  localparam int         WIDTH = 4;
  localparam int         DEPTH = 6;
  localparam int         AW    = 3;
  localparam logic [3:0] RV    = 4'h3;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_err;
  logic             rd_en0;
  logic [AW-1:0]    rd_addr0;
  logic [WIDTH-1:0] rd_data0;
  logic             rd_valid0;
  logic             rd_err0;
  logic             rd_en1;
  logic [AW-1:0]    rd_addr1;
  logic [WIDTH-1:0] rd_data1;
  logic             rd_valid1;
  logic             rd_err1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m [DEPTH];
  logic [WIDTH-1:0] e_rd_data0;
  logic [WIDTH-1:0] e_rd_data1;
  logic             e_rd_valid0;
  logic             e_rd_valid1;
  logic             e_rd_err0;
  logic             e_rd_err1;
  logic             e_wr_err;

  reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .rd_en0    (rd_en0),
    .rd_addr0  (rd_addr0),
    .rd_data0  (rd_data0),
    .rd_valid0 (rd_valid0),
    .rd_err0   (rd_err0),
    .rd_en1    (rd_en1),
    .rd_addr1  (rd_addr1),
    .rd_data1  (rd_data1),
    .rd_valid1 (rd_valid1),
    .rd_err1   (rd_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = RV;
    e_rd_data0  = 4'h0;
    e_rd_data1  = 4'h0;
    e_rd_valid0 = 1'b0;
    e_rd_valid1 = 1'b0;
    e_rd_err0   = 1'b0;
    e_rd_err1   = 1'b0;
    e_wr_err    = 1'b0;
  endtask

  // Reference: update storage first, then reads observe the post-edge contents.
  task automatic model_edge();
    int wa, ra0, ra1;
    wa  = int'(wr_addr);
    ra0 = int'(rd_addr0);
    ra1 = int'(rd_addr1);
    e_wr_err = wr_en && !clr && (wa >= DEPTH);
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) m[i] = RV;
    end else if (wr_en && wa < DEPTH) begin
      m[wa] = wr_data;
    end
    e_rd_valid0 = rd_en0;
    e_rd_err0   = rd_en0 && (ra0 >= DEPTH);
    if (rd_en0) e_rd_data0 = (ra0 >= DEPTH) ? 4'h0 : m[ra0];
    e_rd_valid1 = rd_en1;
    e_rd_err1   = rd_en1 && (ra1 >= DEPTH);
    if (rd_en1) e_rd_data1 = (ra1 >= DEPTH) ? 4'h0 : m[ra1];
  endtask

  task automatic check_all();
    chk("rd_data0",  rd_data0,  e_rd_data0);
    chk("rd_data1",  rd_data1,  e_rd_data1);
    chk("rd_valid0", rd_valid0, e_rd_valid0);
    chk("rd_valid1", rd_valid1, e_rd_valid1);
    chk("rd_err0",   rd_err0,   e_rd_err0);
    chk("rd_err1",   rd_err1,   e_rd_err1);
    chk("wr_err",    wr_err,    e_wr_err);
  endtask

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                      input logic cl, input logic re0, input logic [AW-1:0] ra0,
                      input logic re1, input logic [AW-1:0] ra1);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; clr = cl;
    rd_en0 = re0; rd_addr0 = ra0; rd_en1 = re1; rd_addr1 = ra1;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  // Issue a read, then hit rst between edges and check the pulse is killed at once.
  task automatic mid_reset(input logic [AW-1:0] ra);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, ra, 1'b1, ra);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_rd_valid0", rd_valid0, 1'b0);
    chk("rst_rd_data0",  rd_data0,  4'h0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a += 2) begin
      step(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, AW'(a), 1'b1, AW'(a + 1));
      chk("rst_entry_p0", rd_data0, RV);
      chk("rst_entry_p1", rd_data1, RV);
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0;
    rd_en0 = 1'b0; rd_addr0 = 3'd0; rd_en1 = 1'b0; rd_addr1 = 3'd0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Basic write then read, and the valid pulse lasting one cycle.
    step(1'b1, 3'd3, 4'hA, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    chk("basic_rd_data0",  rd_data0,  4'hA);
    chk("basic_rd_valid0", rd_valid0, 1'b1);
    idle();
    chk("basic_valid_drop", rd_valid0, 1'b0);
    chk("basic_data_hold",  rd_data0,  4'hA);

    // Write-first bypass on both ports.
    step(1'b1, 3'd2, 4'h5, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2);
    chk("bypass_rd_data0", rd_data0, 4'h5);
    chk("bypass_rd_data1", rd_data1, 4'h5);
    chk("bypass_valids",   {rd_valid0, rd_valid1}, 2'b11);

    // Out-of-range write and read.
    step(1'b1, 3'd7, 4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("oor_wr_err", wr_err, 1'b1);
    idle();
    chk("oor_wr_err_drop", wr_err, 1'b0);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 3'd6, 1'b1, 3'd7);
    chk("oor_rd_data0", rd_data0, 4'h0);
    chk("oor_rd_flags0", {rd_valid0, rd_err0}, 2'b11);
    chk("oor_rd_flags1", {rd_valid1, rd_err1}, 2'b11);
    for (int a = 0; a < DEPTH; a += 2) step(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, AW'(a), 1'b1, AW'(a + 1));

    // Clear priority over a simultaneous write; read on the clear edge returns RESET_VAL.
    for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), 4'hC, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b1, 3'd1, 4'h9, 1'b1, 1'b1, 3'd1, 1'b1, 3'd6);
    chk("clr_rd_data0", rd_data0, RV);
    chk("clr_rd_data1_oor", rd_data1, 4'h0);
    chk("clr_wr_err", wr_err, 1'b0);
    for (int a = 0; a < DEPTH; a += 2) begin
      step(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, AW'(a), 1'b1, AW'(a + 1));
      chk("clr_entry_p0", rd_data0, RV);
      chk("clr_entry_p1", rd_data1, RV);
    end

    // Asynchronous reset in the middle of traffic.
    step(1'b1, 3'd4, 4'h7, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    mid_reset(3'd4);

    // Randomized regression, with the occasional clear and reset.
    for (int i = 0; i < 10000; i++) begin
      if (i % 2500 == 1250) begin
        mid_reset(AW'($urandom_range(0, 7)));
      end else begin
        step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), WIDTH'($urandom),
             ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
